splinker_zone_ctrl: RTL and testbench

SPLINKER_ZONE_CTRL -- requirements
Module: splinker_zone_ctrl

---
 rtl/splinker_zone_ctrl.sv | 141 ++++++++++++++
 tb/tb_splinker_zone_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/splinker_zone_ctrl.sv
// Round-robin irrigation sequencer: opens one zone valve, runs the pump for a
// bounded time (aborting on wet soil or empty reservoir), then rests all-off.
module splinker_zone_ctrl #(
  parameter int ZONES      = 4,
  parameter int RUN_CYCLES = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ZONES-1:0]           earth_humidity,
  input  logic                       air_humidity,
  input  logic                       low_temperature,
  input  logic                       mid_water_level,
  input  logic                       water_empty,
  output logic                       splinker_bomb,
  output logic [ZONES-1:0]           zone_valve,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic                       busy
);

  localparam int AW      = $clog2(ZONES);
  localparam int MAX_CYC = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] RUN_LOAD = TW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, WATER, GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   active_zone_q, active_zone_d;
  logic            bomb_q, bomb_d;
  logic [ZONES-1:0] valve_q, valve_d;

  logic [ZONES-1:0] demand;
  logic [ZONES-1:0] sel_onehot;
  logic [ZONES-1:0] act_onehot;
  logic             sel_found;
  logic [AW-1:0]    sel_idx;
  logic [AW-1:0]    rr_after_visit;
  logic             water_abort;
  int               idx_int;

  // Weather gating is shared; only soil wetness is per zone.
  for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
    assign demand[gi]     = !earth_humidity[gi]
                            & (!air_humidity | (!low_temperature & mid_water_level))
                            & !water_empty;
    assign sel_onehot[gi] = (sel_idx == AW'(gi));
    assign act_onehot[gi] = (active_zone_q == AW'(gi));
  end

  // First demanding zone at or after rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx_int   = 0;
    for (int k = 0; k < ZONES; k++) begin
      idx_int = int'(rr_ptr_q) + k;
      if (idx_int >= ZONES) idx_int = idx_int - ZONES;
      if (!sel_found && demand[idx_int]) begin
        sel_found = 1'b1;
        sel_idx   = AW'(idx_int);
      end
    end
  end

  assign rr_after_visit = (active_zone_q == AW'(ZONES - 1)) ? '0 : active_zone_q + 1'b1;
  assign water_abort    = earth_humidity[active_zone_q] | water_empty;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rr_ptr_d      = rr_ptr_q;
    active_zone_d = active_zone_q;
    bomb_d        = 1'b0;
    valve_d       = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d       = OPEN;
          active_zone_d = sel_idx;
          valve_d       = sel_onehot;
        end
      end
      OPEN: begin
        if (water_empty) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          state_d = WATER;
          timer_d = RUN_LOAD;
          bomb_d  = 1'b1;
          valve_d = act_onehot;
        end
      end
      WATER: begin
        if (water_abort || timer_q == '0) begin
          state_d  = GAP;
          timer_d  = GAP_LOAD;
          rr_ptr_d = rr_after_visit;
        end else begin
          timer_d = timer_q - 1'b1;
          bomb_d  = 1'b1;
          valve_d = act_onehot;
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      rr_ptr_q      <= '0;
      active_zone_q <= '0;
      bomb_q        <= 1'b0;
      valve_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rr_ptr_q      <= rr_ptr_d;
      active_zone_q <= active_zone_d;
      bomb_q        <= bomb_d;
      valve_q       <= valve_d;
    end
  end

  assign splinker_bomb = bomb_q;
  assign zone_valve    = valve_q;
  assign active_zone   = active_zone_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_splinker_zone_ctrl.sv
// Randomized bench: a visit-timeline reference model fills a queue of expected
// per-cycle outputs; an independent monitor pops and compares on the falling edge.
module tb_splinker_zone_ctrl;
  localparam int ZONES = 4;
  localparam int RUN   = 16;
  localparam int GAPC  = 4;
  localparam int AW    = $clog2(ZONES);

  logic             clk = 1'b0;
  logic             reset;
  logic [ZONES-1:0] earth_humidity;
  logic             air_humidity, low_temperature, mid_water_level, water_empty;
  logic             splinker_bomb;
  logic [ZONES-1:0] zone_valve;
  logic [AW-1:0]    active_zone;
  logic             busy;

  splinker_zone_ctrl #(.ZONES(ZONES), .RUN_CYCLES(RUN), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .earth_humidity(earth_humidity),
    .air_humidity(air_humidity), .low_temperature(low_temperature),
    .mid_water_level(mid_water_level), .water_empty(water_empty),
    .splinker_bomb(splinker_bomb), .zone_valve(zone_valve),
    .active_zone(active_zone), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             bomb;
    logic [ZONES-1:0] valve;
    logic [AW-1:0]    az;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a visit is a timeline t=0 (valve only), t=1..pump_end (pump),
  // then GAPC rest cycles starting at gap_start.
  bit m_visit = 0;
  int m_t = 0, m_zone = 0, m_rr = 0, m_gap_start = -1;

  function automatic bit zone_wants(int z);
    return !earth_humidity[z] && (!air_humidity || (!low_temperature && mid_water_level))
           && !water_empty;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_visit = 0; m_rr = 0; m_zone = 0; m_t = 0; m_gap_start = -1;
      end else if (!m_visit) begin
        for (int k = 0; k < ZONES; k++) begin
          if (!m_visit && zone_wants((m_rr + k) % ZONES)) begin
            m_visit = 1; m_zone = (m_rr + k) % ZONES; m_t = 0; m_gap_start = -1;
          end
        end
      end else begin
        if (m_gap_start < 0) begin
          if (m_t == 0) begin
            if (water_empty) m_gap_start = 1;
          end else if (earth_humidity[m_zone] || water_empty || m_t == RUN) begin
            m_gap_start = m_t + 1;
            m_rr = (m_zone + 1) % ZONES;
          end
        end else if (m_t == m_gap_start + GAPC - 1) begin
          m_visit = 0;
        end
        m_t++;
      end
      e.az   = AW'(m_zone);
      e.busy = m_visit;
      e.bomb = 1'b0;
      e.valve = '0;
      if (m_visit && (m_gap_start < 0 || m_t < m_gap_start)) begin
        e.valve = ZONES'(1) << m_zone;
        e.bomb  = (m_t != 0);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    exp_t e;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (splinker_bomb !== e.bomb || zone_valve !== e.valve ||
            active_zone !== e.az || busy !== e.busy) begin
          errors++;
          $display("FAIL outputs t=%0t: got bomb=%b valve=%b zone=%0d busy=%b, expected bomb=%b valve=%b zone=%0d busy=%b",
                   $time, splinker_bomb, zone_valve, active_zone, busy,
                   e.bomb, e.valve, e.az, e.busy);
        end
        if (prev_busy && !e.busy)
          $display("visit done: zone=%0d at t=%0t", e.az, $time);
        prev_busy = e.busy;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pump(input string what);
    int n = 0;
    while (!splinker_bomb && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: pump never started within 200 cycles (got bomb=%b, required 1)",
               what, splinker_bomb);
    end
  endtask

  initial begin
    reset = 1'b1; earth_humidity = '1; air_humidity = 1'b0; low_temperature = 1'b0;
    mid_water_level = 1'b0; water_empty = 1'b0;
    cyc(3);
    reset = 1'b0;
    // Single dry zone 0.
    earth_humidity = 4'b1110; cyc(22); earth_humidity = '1; cyc(5);
    // All zones dry: full round robin.
    earth_humidity = 4'b0000; cyc(5 * 21 + 3); earth_humidity = '1; cyc(25);
    // Humid air gated by temperature and reservoir level.
    air_humidity = 1'b1; mid_water_level = 1'b1; earth_humidity = 4'b1011; cyc(22);
    earth_humidity = '1; cyc(25);
    mid_water_level = 1'b0; earth_humidity = 4'b1011; cyc(20);
    air_humidity = 1'b0; earth_humidity = '1; cyc(3);
    // Zone 1 soil turns wet mid-watering.
    earth_humidity = 4'b1101; wait_pump("zone1_start"); cyc(4); earth_humidity = '1; cyc(25);
    // Reservoir empties mid-watering and stays empty for a while.
    earth_humidity = 4'b0111; wait_pump("zone3_start"); cyc(2); water_empty = 1'b1; cyc(30);
    water_empty = 1'b0; earth_humidity = '1; cyc(25);
    // Empty reservoir during the valve-open cycle.
    earth_humidity = 4'b1110; @(posedge busy); cyc(1); water_empty = 1'b1; cyc(8);
    water_empty = 1'b0; earth_humidity = '1; cyc(25);
    // Reset in the middle of watering.
    earth_humidity = 4'b1011; wait_pump("zone2_start"); cyc(9);
    reset = 1'b1; cyc(1); reset = 1'b0; earth_humidity = 4'b0000; cyc(30);
    // Random weather and soil.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) earth_humidity = ZONES'($urandom);
      if ($urandom_range(15) == 0) begin
        air_humidity    = 1'($urandom);
        low_temperature = 1'($urandom);
        mid_water_level = 1'($urandom);
      end
      if ($urandom_range(31) == 0) water_empty = ($urandom_range(3) == 0);
      reset = ($urandom_range(499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end
endmodule
